// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Arbitrates two requesters onto one 512x32 byte-enabled data memory. The
// memory reads asynchronously and writes on the rising clock edge.
// Port 0 (core load/store) has fixed priority. Port 1 (loader/DMA) is
// force-granted for one cycle after waiting MAX_WAIT consecutive cycles.
//
// Parameters:
//   MAX_WAIT  cycles port 1 may be held off before a forced grant (0 = never)
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   pN_valid/we/addr/wdata/be   request from port N (N = 0, 1)
//   pN_ready                    request accepted this cycle (combinational)
//   pN_rvalid/rdata             registered response, one cycle after accept
//   mem_addr/wdata/be/wren      memory request from the granted port
//   mem_rdata                   asynchronous memory read word
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  input  logic        p0_we,
  input  logic [10:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_be,
  output logic        p0_ready,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_valid,
  input  logic        p1_we,
  input  logic [10:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_be,
  output logic        p1_ready,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic [10:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_wren,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (MAX_WAIT == 32'd0) ? 1 : $clog2(MAX_WAIT + 32'd1);
  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
  localparam bit FORCE_EN = (MAX_WAIT != 32'd0);

  logic [CNT_W-1:0] wait_cnt_r;
  logic             force_s;
  logic             gnt0_s;
  logic             gnt1_s;
  logic             mem_wren_s;
  logic             p0_rvalid_r;
  logic             p1_rvalid_r;
  logic [31:0]      p0_rdata_r;
  logic [31:0]      p1_rdata_r;

  // Grant selection: port 0 priority unless port 1 has waited long enough.
  always_comb begin
    force_s = 1'b0;
    if (FORCE_EN && (wait_cnt_r >= MAX_WAIT_C) && p1_valid) begin
      force_s = 1'b1;
    end else begin
      force_s = 1'b0;
    end
    gnt1_s = p1_valid && (!p0_valid || force_s);
    gnt0_s = p0_valid && !gnt1_s;
  end

  // Memory request mux; the raw grant steers the fields even during reset.
  always_comb begin
    mem_addr   = 11'd0;
    mem_wdata  = 32'd0;
    mem_be     = 4'd0;
    mem_wren_s = 1'b0;
    case ({gnt1_s, gnt0_s})
      2'b10: begin
        mem_addr   = p1_addr;
        mem_wdata  = p1_wdata;
        mem_be     = p1_be;
        mem_wren_s = p1_we;
      end
      2'b01: begin
        mem_addr   = p0_addr;
        mem_wdata  = p0_wdata;
        mem_be     = p0_be;
        mem_wren_s = p0_we;
      end
      default: begin
        mem_addr   = 11'd0;
        mem_wdata  = 32'd0;
        mem_be     = 4'd0;
        mem_wren_s = 1'b0;
      end
    endcase
  end

  // Reset blocks every accept and every memory write.
  assign p0_ready  = gnt0_s & ~rst;
  assign p1_ready  = gnt1_s & ~rst;
  assign mem_wren  = mem_wren_s & ~rst;

  assign p0_rvalid = p0_rvalid_r;
  assign p1_rvalid = p1_rvalid_r;
  assign p0_rdata  = p0_rdata_r;
  assign p1_rdata  = p1_rdata_r;

  // Response registers: capture the pre-write word on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_rvalid_r <= 1'b0;
      p1_rvalid_r <= 1'b0;
      p0_rdata_r  <= 32'd0;
      p1_rdata_r  <= 32'd0;
    end else begin
      p0_rvalid_r <= p0_valid & p0_ready;
      p1_rvalid_r <= p1_valid & p1_ready;
      if (p0_valid & p0_ready) begin
        p0_rdata_r <= mem_rdata;
      end else begin
        p0_rdata_r <= p0_rdata_r;
      end
      if (p1_valid & p1_ready) begin
        p1_rdata_r <= mem_rdata;
      end else begin
        p1_rdata_r <= p1_rdata_r;
      end
    end
  end

  // Port 1 starvation counter, saturating at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (!p1_valid || p1_ready) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (wait_cnt_r < MAX_WAIT_C) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vectors, a reference model of the
// arbitration/memory/response rules checked every cycle, and literal checks.
module tb_dmem_arbiter;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p0_we, p1_valid, p1_we;
  logic [10:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic [3:0]  p0_be, p1_be;
  logic        p0_ready, p0_rvalid, p1_ready, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_wren;

  // second instance with forcing disabled
  logic        nf_p0_ready, nf_p0_rvalid, nf_p1_ready, nf_p1_rvalid;
  logic [31:0] nf_p0_rdata, nf_p1_rdata;
  logic [10:0] nf_mem_addr;
  logic [31:0] nf_mem_wdata, nf_mem_rdata;
  logic [3:0]  nf_mem_be;
  logic        nf_mem_wren;

  logic [31:0] dmem   [512];
  logic [31:0] nf_mem [512];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MW)) u_dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_be(p0_be), .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_be(p1_be), .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_wren(mem_wren), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.MAX_WAIT(0)) u_nf (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_be(p0_be), .p0_ready(nf_p0_ready), .p0_rvalid(nf_p0_rvalid), .p0_rdata(nf_p0_rdata),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_be(p1_be), .p1_ready(nf_p1_ready), .p1_rvalid(nf_p1_rvalid), .p1_rdata(nf_p1_rdata),
    .mem_addr(nf_mem_addr), .mem_wdata(nf_mem_wdata), .mem_be(nf_mem_be),
    .mem_wren(nf_mem_wren), .mem_rdata(nf_mem_rdata)
  );

  // memories attached to the two instances
  assign mem_rdata    = dmem[mem_addr[10:2]];
  assign nf_mem_rdata = nf_mem[nf_mem_addr[10:2]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_wren && mem_be[b]) dmem[mem_addr[10:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (nf_mem_wren && nf_mem_be[b]) nf_mem[nf_mem_addr[10:2]][8*b +: 8] <= nf_mem_wdata[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          p1_wait;          // consecutive cycles port 1 has been refused
  logic [31:0] ref_mem [512];
  logic        e_rv0, e_rv1;
  logic [31:0] e_rd0, e_rd1;

  function automatic bit m_gnt1();
    return p1_valid && (!p0_valid || (MW > 0 && p1_wait >= MW));
  endfunction

  function automatic bit m_gnt0();
    return p0_valid && !m_gnt1();
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      e_rv0 <= 1'b0; e_rv1 <= 1'b0;
      e_rd0 <= 32'd0; e_rd1 <= 32'd0;
      p1_wait <= 0;
    end else begin
      e_rv0 <= m_gnt0();
      e_rv1 <= m_gnt1();
      if (m_gnt0()) e_rd0 <= ref_mem[p0_addr / 4];
      if (m_gnt1()) e_rd1 <= ref_mem[p1_addr / 4];
      for (int b = 0; b < 4; b++) begin
        if (m_gnt0() && p0_we && p0_be[b]) ref_mem[p0_addr / 4][8*b +: 8] <= p0_wdata[8*b +: 8];
        if (m_gnt1() && p1_we && p1_be[b]) ref_mem[p1_addr / 4][8*b +: 8] <= p1_wdata[8*b +: 8];
      end
      p1_wait <= (!p1_valid || m_gnt1()) ? 0 : ((p1_wait < MW) ? p1_wait + 1 : p1_wait);
    end
  end

  // compare process: every cycle, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("p0_ready", p0_ready, m_gnt0() && !rst);
      check("p1_ready", p1_ready, m_gnt1() && !rst);
      check("mem_wren", mem_wren,
            !rst && ((m_gnt1() && p1_we) || (m_gnt0() && p0_we)));
      check("mem_addr", mem_addr, m_gnt1() ? p1_addr : (m_gnt0() ? p0_addr : 11'd0));
      check("mem_wdata", mem_wdata, m_gnt1() ? p1_wdata : (m_gnt0() ? p0_wdata : 32'd0));
      check("mem_be", mem_be, m_gnt1() ? p1_be : (m_gnt0() ? p0_be : 4'd0));
      check("p0_rvalid", p0_rvalid, e_rv0);
      check("p1_rvalid", p1_rvalid, e_rv1);
      check("p0_rdata", p0_rdata, e_rd0);
      check("p1_rdata", p1_rdata, e_rd1);
      check("nf_p0_ready", nf_p0_ready, p0_valid && !rst);
      check("nf_p1_ready", nf_p1_ready, p1_valid && !p0_valid && !rst);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic we, input logic [10:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = d; p0_be = be;
  endtask

  task automatic set1(input logic v, input logic we, input logic [10:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = d; p1_be = be;
  endtask

  int n_p1, first_p1, nf_n_p1;

  initial begin
    for (int i = 0; i < 512; i++) begin
      dmem[i]    = 32'hA500_0000 | i;
      nf_mem[i]  = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    // reset with both ports requesting writes
    rst = 1'b1;
    set0(1'b1, 1'b1, 11'h010, 32'h1111_1111, 4'hF);
    set1(1'b1, 1'b1, 11'h020, 32'h2222_2222, 4'hF);
    cyc();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_p0_ready", p0_ready, 1'b0);
    check("rst_p1_ready", p1_ready, 1'b0);
    check("rst_wren", mem_wren, 1'b0);
    cyc();
    rst = 1'b0;
    set0(1'b0, 1'b0, 11'h000, 32'd0, 4'h0);
    set1(1'b0, 1'b0, 11'h000, 32'd0, 4'h0);
    @(negedge clk);
    check("post_rst_rv0", p0_rvalid, 1'b0);
    check("post_rst_rv1", p1_rvalid, 1'b0);
    check("post_rst_mem4", dmem[4], 32'hA500_0004);
    check("post_rst_mem8", dmem[8], 32'hA500_0008);

    // port 0 write / masked write / read
    cyc();
    set0(1'b1, 1'b1, 11'h010, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    check("wr_ready", p0_ready, 1'b1);
    cyc();
    set0(1'b1, 1'b1, 11'h010, 32'h0000_AA00, 4'h2);
    @(negedge clk);
    check("wr_old_rv", p0_rvalid, 1'b1);
    check("wr_old_word", p0_rdata, 32'hA500_0004);
    cyc();
    set0(1'b1, 1'b0, 11'h010, 32'd0, 4'h0);
    @(negedge clk);
    check("bw_old_word", p0_rdata, 32'hDEAD_BEEF);
    cyc();
    set0(1'b0, 1'b0, 11'h000, 32'd0, 4'h0);
    @(negedge clk);
    check("rd_masked", p0_rdata, 32'hDEAD_AAEF);

    // contention: p0 reads, p1 writes, both held high
    cyc();
    set0(1'b1, 1'b0, 11'h000, 32'd0, 4'hF);
    set1(1'b1, 1'b1, 11'h100, 32'hCAFE_0001, 4'hF);
    n_p1 = 0; first_p1 = -1; nf_n_p1 = 0;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      if (p1_ready) begin
        n_p1++;
        if (first_p1 < 0) first_p1 = i;
      end
      if (nf_p1_ready) nf_n_p1++;
      if (i == 7) check("cont_c7_wren", mem_wren, 1'b0);
      if (i == 8) begin
        check("cont_c8_p0", p0_ready, 1'b0);
        check("cont_c8_wren", mem_wren, 1'b1);
      end
      cyc();
    end
    check("cont_first_p1", first_p1, 32'd8);
    check("cont_n_p1", n_p1, 32'd3);
    check("nf_n_p1", nf_n_p1, 32'd0);
    set0(1'b0, 1'b0, 11'h000, 32'd0, 4'h0);
    @(negedge clk);
    check("nf_p1_on_drop", nf_p1_ready, 1'b1);

    // read-after-write across ports at the top word
    cyc();
    set1(1'b0, 1'b0, 11'h000, 32'd0, 4'h0);
    set0(1'b1, 1'b1, 11'h7FC, 32'h1234_5678, 4'hF);
    cyc();
    set0(1'b0, 1'b0, 11'h000, 32'd0, 4'h0);
    set1(1'b1, 1'b0, 11'h7FC, 32'd0, 4'h0);
    cyc();
    set1(1'b1, 1'b0, 11'h7FE, 32'd0, 4'h0);
    @(negedge clk);
    check("raw_7fc", p1_rdata, 32'h1234_5678);
    cyc();
    set1(1'b0, 1'b0, 11'h000, 32'd0, 4'h0);
    @(negedge clk);
    check("raw_7fe", p1_rdata, 32'h1234_5678);
    check("raw_7fe_rv", p1_rvalid, 1'b1);

    // reset mid-operation, then an empty write
    cyc();
    rst = 1'b1;
    set1(1'b1, 1'b1, 11'h020, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    check("midrst_wren", mem_wren, 1'b0);
    cyc();
    rst = 1'b0;
    set1(1'b1, 1'b1, 11'h020, 32'h3333_3333, 4'h0);
    @(negedge clk);
    check("midrst_rv1", p1_rvalid, 1'b0);
    check("midrst_mem8", dmem[8], 32'hA500_0008);
    check("empty_wren", mem_wren, 1'b1);
    cyc();
    set1(1'b0, 1'b0, 11'h000, 32'd0, 4'h0);
    @(negedge clk);
    check("empty_mem8", dmem[8], 32'hA500_0008);
    check("empty_rdata", p1_rdata, 32'hA500_0008);
    cyc();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
